// File: rtl/median_pkg.sv
// Shared types and helpers for the MED median sequencer.
//   med_state_t : sequencer state encoding (IDLE, LOAD, SORT, DONE)
//   N_PIX_DEF   : default pixels per window
//   cmp_len     : compare-exchange cycles in a non-final sort pass
package median_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SORT = 2'd2,
        DONE = 2'd3
    } med_state_t;

    localparam int unsigned N_PIX_DEF = 9;

    // Pass p compares one fewer pair than pass p-1; the rest of the pass recirculates.
    function automatic int unsigned cmp_len(input int unsigned n_pix, input int unsigned p);
        return n_pix - 1 - p;
    endfunction

endpackage

// File: rtl/median_ctrl.sv
// Sequencer for the MED median datapath. Collects an N_PIX-pixel burst on DSI,
// then drives the BYP load/compare/recirculate schedule and pulses DSO when
// MED.DO holds the median.
// Ports:
//   CLK  : clock, rising edge
//   nRST : synchronous active-low reset
//   DSI  : pixel strobe, one pixel per cycle while high
//   BYP  : to MED.BYP, 1 = shift/recirculate, 0 = compare-exchange
//   DSO  : one-cycle pulse, MED.DO holds the median
//   RDY  : a new window may start (IDLE or DONE)
module median_ctrl
    import median_pkg::*;
#(
    parameter int unsigned N_PIX = N_PIX_DEF
) (
    input  logic CLK,
    input  logic nRST,
    input  logic DSI,
    output logic BYP,
    output logic DSO,
    output logic RDY
);

    localparam int unsigned P       = (N_PIX + 1) / 2;
    localparam int unsigned PIX_W   = $clog2(N_PIX);
    localparam int unsigned P_W     = $clog2(P);
    localparam int unsigned FIN_LEN = (N_PIX - 1) / 2;

    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(N_PIX - 1);
    localparam logic [P_W-1:0]   LAST_P   = P_W'(P - 1);
    localparam logic [PIX_W-1:0] FIN_LAST = PIX_W'(FIN_LEN - 1);

    med_state_t       state_q, state_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic [PIX_W-1:0] s_q, s_d;
    logic [P_W-1:0]   p_q, p_d;
    logic             byp_q, byp_d;
    logic             dso_q, dso_d;
    logic             rdy_q, rdy_d;

    // Next state/counters, then the Moore outputs decoded from the next state
    // so the output flops present them in the same cycle as the state.
    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        s_d     = s_q;
        p_d     = p_q;
        byp_d   = 1'b1;
        dso_d   = 1'b0;
        rdy_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (DSI) begin
                    state_d = LOAD;
                    pix_d   = PIX_W'(1);
                end
            end
            LOAD: begin
                if (!DSI) begin
                    // Short burst: drop the partial window.
                    state_d = IDLE;
                    pix_d   = '0;
                end else if (pix_q == LAST_PIX) begin
                    state_d = SORT;
                    pix_d   = '0;
                    s_d     = '0;
                    p_d     = '0;
                end else begin
                    pix_d = pix_q + PIX_W'(1);
                end
            end
            SORT: begin
                // DSI is deliberately ignored while sorting.
                if (p_q == LAST_P) begin
                    if (s_q == FIN_LAST) begin
                        state_d = DONE;
                        s_d     = '0;
                        p_d     = '0;
                    end else begin
                        s_d = s_q + PIX_W'(1);
                    end
                end else if (s_q == LAST_PIX) begin
                    s_d = '0;
                    p_d = p_q + P_W'(1);
                end else begin
                    s_d = s_q + PIX_W'(1);
                end
            end
            DONE: begin
                if (DSI) begin
                    // Back-to-back window: this pixel is pixel 0.
                    state_d = LOAD;
                    pix_d   = PIX_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                pix_d   = '0;
                s_d     = '0;
                p_d     = '0;
            end
        endcase

        unique case (state_d)
            IDLE: rdy_d = 1'b1;
            LOAD: byp_d = 1'b1;
            SORT: begin
                // Final pass is all compare; earlier passes compare then recirculate.
                if (p_d == LAST_P) begin
                    byp_d = 1'b0;
                end else begin
                    byp_d = !(32'(s_d) < cmp_len(N_PIX, 32'(p_d)));
                end
            end
            DONE: begin
                dso_d = 1'b1;
                rdy_d = 1'b1;
            end
            default: rdy_d = 1'b1;
        endcase
    end

    // State, counters and output registers; reset returns to IDLE from anywhere.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            pix_q   <= '0;
            s_q     <= '0;
            p_q     <= '0;
            byp_q   <= 1'b1;
            dso_q   <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            s_q     <= s_d;
            p_q     <= p_d;
            byp_q   <= byp_d;
            dso_q   <= dso_d;
            rdy_q   <= rdy_d;
        end
    end

    assign BYP = byp_q;
    assign DSO = dso_q;
    assign RDY = rdy_q;

endmodule

// File: tb/tb_median_ctrl.sv
// Self-checking bench for median_ctrl: directed schedule/abort/back-to-back/
// reset scenarios plus a long randomized run against a window-level model.
module tb_median_ctrl;
    import median_pkg::*;

    localparam int unsigned N = N_PIX_DEF;
    localparam int unsigned P = (N + 1) / 2;

    logic CLK = 1'b0;
    logic nRST;
    logic DSI;
    logic BYP;
    logic DSO;
    logic RDY;

    always #5 CLK = ~CLK;

    median_ctrl #(.N_PIX(N)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .DSI  (DSI),
        .BYP  (BYP),
        .DSO  (DSO),
        .RDY  (RDY)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_cmp++;
        if (got !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Window model: BYP schedule for the whole sort phase, built from the pass rules.
    bit sched[$];
    int loaded = 0;
    int sidx   = -1;
    bit mdone  = 1'b0;

    function automatic void build_sched();
        sched.delete();
        for (int p = 0; p < int'(P) - 1; p++)
            for (int s = 0; s < int'(N); s++)
                sched.push_back(s < int'(N) - 1 - p ? 1'b0 : 1'b1);
        for (int s = 0; s < (int'(N) - 1) / 2; s++)
            sched.push_back(1'b0);
    endfunction

    function automatic void model_step(input bit dsi, input bit rst_n);
        if (!rst_n) begin
            loaded = 0;
            sidx   = -1;
            mdone  = 1'b0;
        end else if (sidx >= 0) begin
            sidx++;
            if (sidx == sched.size()) begin
                sidx  = -1;
                mdone = 1'b1;
            end
        end else if (loaded > 0) begin
            if (dsi) begin
                loaded++;
                if (loaded == int'(N)) begin
                    loaded = 0;
                    sidx   = 0;
                end
            end else begin
                loaded = 0;
            end
        end else begin
            mdone  = 1'b0;
            loaded = dsi ? 1 : 0;
        end
    endfunction

    // Apply inputs for one cycle, advance the model, check all outputs mid-cycle.
    task automatic cycle(input bit dsi, input bit rst_n);
        DSI  = dsi;
        nRST = rst_n;
        @(posedge CLK);
        model_step(dsi, rst_n);
        @(negedge CLK);
        chk("model_byp", BYP, (sidx >= 0) ? int'(sched[sidx]) : 1);
        chk("model_dso", DSO, int'(mdone));
        chk("model_rdy", RDY, (sidx < 0 && loaded == 0) ? 1 : 0);
    endtask

    // Literal nominal timeline for N=9, cycle 0 = first pixel, DSI low from cycle 49.
    function automatic int t2_byp(input int c);
        if ((c >= 9 && c <= 16) || (c >= 18 && c <= 24) || (c >= 27 && c <= 32) ||
            (c >= 36 && c <= 40) || (c >= 45 && c <= 48))
            return 0;
        return 1;
    endfunction

    task automatic chk_nominal(input int c);
        chk($sformatf("sched_byp_c%0d", c), BYP, t2_byp(c));
        chk($sformatf("sched_dso_c%0d", c), DSO, (c == 49) ? 1 : 0);
        chk($sformatf("sched_rdy_c%0d", c), RDY, (c == 0 || c >= 49) ? 1 : 0);
    endtask

    initial begin
        int dso_cnt;
        int dso_at;
        int dso_a;
        int dso_b;

        build_sched();
        DSI  = 1'b0;
        nRST = 1'b0;
        @(negedge CLK);

        // T1: reset dominates a high strobe.
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0);
        chk("rst_byp", BYP, 1);
        chk("rst_dso", DSO, 0);
        chk("rst_rdy", RDY, 1);

        // T2: nominal burst right after reset release.
        chk_nominal(0);
        for (int k = 0; k < 56; k++) begin
            cycle(k <= 8, 1'b1);
            chk_nominal(k + 1);
        end

        // T3: abort after 5 pixels, then a full burst.
        dso_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            cycle(k <= 4, 1'b1);
            if (k + 1 == 6) chk("abort_idle_rdy", RDY, 1);
            if (DSO === 1'b1) dso_cnt++;
        end
        chk("abort_no_dso", dso_cnt, 0);
        dso_at = -1;
        for (int k = 0; k < 60; k++) begin
            cycle(k <= 8, 1'b1);
            if (DSO === 1'b1 && dso_at < 0) dso_at = k + 1;
        end
        chk("abort_next_dso_at", dso_at, 49);

        // T4: random strobe noise while sorting must not disturb the schedule.
        chk_nominal(0);
        for (int k = 0; k < 56; k++) begin
            cycle((k <= 8) || (k >= 9 && k <= 48 && $urandom_range(0, 1) == 1), 1'b1);
            chk_nominal(k + 1);
        end

        // T5a: strobe held high gives back-to-back medians.
        dso_a = -1;
        dso_b = -1;
        for (int k = 0; k < 100; k++) begin
            cycle(1'b1, 1'b1);
            if (DSO === 1'b1) begin
                if (dso_a < 0) dso_a = k + 1;
                else if (dso_b < 0) dso_b = k + 1;
            end
        end
        chk("b2b_dso_first", dso_a, 49);
        chk("b2b_dso_second", dso_b, 98);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1);

        // T5b: reset at cycle 30 kills the window.
        dso_cnt = 0;
        for (int k = 0; k < 80; k++) begin
            cycle(k <= 8, k != 30);
            if (k + 1 == 31) begin
                chk("midrst_byp", BYP, 1);
                chk("midrst_rdy", RDY, 1);
            end
            if (DSO === 1'b1) dso_cnt++;
        end
        chk("midrst_no_dso", dso_cnt, 0);

        // Randomized run: mostly-high strobe with occasional resets.
        for (int k = 0; k < 3000; k++)
            cycle($urandom_range(0, 99) < 90, $urandom_range(0, 299) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
